// File: rtl/vx_warp_issue_sched.sv
// Warp issue scheduler: picks active, unstalled warps round-robin, holds the
// offer under backpressure, and tracks per-warp PC, thread mask and stall state.
module vx_warp_issue_sched #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter logic [PC_BITS-1:0] STARTUP_PC = '0,
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   sched_valid,
  input  logic                   sched_ready,
  output logic [NW_WIDTH-1:0]    sched_wid,
  output logic [NUM_THREADS-1:0] sched_tmask,
  output logic [PC_BITS-1:0]     sched_pc,
  input  logic                   sched_stall,
  input  logic                   unstall_valid,
  input  logic [NW_WIDTH-1:0]    unstall_wid,
  input  logic                   tmc_valid,
  input  logic [NW_WIDTH-1:0]    tmc_wid,
  input  logic [NUM_THREADS-1:0] tmc_tmask,
  input  logic                   br_valid,
  input  logic [NW_WIDTH-1:0]    br_wid,
  input  logic                   br_taken,
  input  logic [PC_BITS-1:0]     br_pc,
  input  logic                   wspawn_valid,
  input  logic [NUM_WARPS-1:0]   wspawn_mask,
  input  logic [PC_BITS-1:0]     wspawn_pc,
  output logic [NUM_WARPS-1:0]   active_warps,
  output logic [NUM_WARPS-1:0]   stalled_warps,
  output logic                   busy
);

  logic [NUM_WARPS-1:0]   active_r;
  logic [NUM_WARPS-1:0]   stalled_r;
  logic [NUM_THREADS-1:0] tmask_r [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_r    [NUM_WARPS];
  logic [NW_WIDTH-1:0]    rr_last;
  logic [NW_WIDTH-1:0]    hold_wid;
  logic                   hold_valid;
  logic [NW_WIDTH-1:0]    sel_wid;
  logic                   sel_found;
  logic [NW_WIDTH:0]      cand;
  logic [NUM_WARPS-1:0]   eligible;
  logic                   fire;

  assign eligible = active_r & ~stalled_r;

  // Scan upward from the warp after rr_last; one conditional subtract wraps
  // the index because rr_last + k never reaches 2*NUM_WARPS.
  always_comb begin
    sel_found = 1'b0;
    sel_wid   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      cand = {1'b0, rr_last} + (NW_WIDTH+1)'(k);
      if (cand >= (NW_WIDTH+1)'(NUM_WARPS)) begin
        cand = cand - (NW_WIDTH+1)'(NUM_WARPS);
      end
      if (!sel_found && eligible[cand[NW_WIDTH-1:0]]) begin
        sel_found = 1'b1;
        sel_wid   = cand[NW_WIDTH-1:0];
      end
    end
  end

  assign sched_valid   = ~reset & (hold_valid | (|eligible));
  assign sched_wid     = hold_valid ? hold_wid : sel_wid;
  assign sched_tmask   = tmask_r[sched_wid];
  assign sched_pc      = pc_r[sched_wid];
  assign fire          = sched_valid & sched_ready;
  assign active_warps  = active_r;
  assign stalled_warps = stalled_r;
  assign busy          = |active_r;

  // Release events only act on stalled warps, so they never collide with the
  // fired warp (always unstalled) or with spawns (always inactive targets).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r   <= NUM_WARPS'(1);
      stalled_r  <= '0;
      rr_last    <= NW_WIDTH'(NUM_WARPS - 1);
      hold_valid <= 1'b0;
      hold_wid   <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        tmask_r[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
        pc_r[i]    <= STARTUP_PC;
      end
    end else begin
      if (fire) begin
        rr_last    <= sched_wid;
        hold_valid <= 1'b0;
      end else if (sched_valid) begin
        hold_valid <= 1'b1;
        hold_wid   <= sched_wid;
      end
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (stalled_r[i]) begin
          if (unstall_valid && unstall_wid == NW_WIDTH'(i)) begin
            stalled_r[i] <= 1'b0;
          end
          if (tmc_valid && tmc_wid == NW_WIDTH'(i)) begin
            tmask_r[i]   <= tmc_tmask;
            stalled_r[i] <= 1'b0;
            if (tmc_tmask == '0) begin
              active_r[i] <= 1'b0;
            end
          end
          if (br_valid && br_wid == NW_WIDTH'(i)) begin
            if (br_taken) begin
              pc_r[i] <= br_pc;
            end
            stalled_r[i] <= 1'b0;
          end
        end
        if (wspawn_valid && wspawn_mask[i] && !active_r[i] && i != 0) begin
          active_r[i]  <= 1'b1;
          stalled_r[i] <= 1'b0;
          pc_r[i]      <= wspawn_pc;
          tmask_r[i]   <= NUM_THREADS'(1);
        end
        if (fire && sched_wid == NW_WIDTH'(i)) begin
          pc_r[i] <= pc_r[i] + PC_BITS'(2);
          if (sched_stall) begin
            stalled_r[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
